// File: rtl/multdiv_pkg.sv
// Shared definitions for the multdiv unit.
//   - DIV_WIDTH  : default operand/result width of the divider
//   - div_state_e: divider FSM states (IDLE, RUN, FIX)
//   - cnt_width(): width of the iteration counter for a given operand width
package multdiv_pkg;

   localparam int unsigned DIV_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIX
   } div_state_e;

   // Must be able to hold the value WIDTH itself, not just WIDTH-1.
   function automatic int unsigned cnt_width(input int unsigned w);
      return $clog2(w) + 1;
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration (purely combinational).
// Ports:
//   rem_i  : partial remainder before the step
//   quo_i  : quotient register before the step (upper bits still hold dividend bits)
//   dvsr_i : divisor magnitude
//   rem_o  : partial remainder after the step
//   quo_o  : quotient register after the step
module div_step
   import multdiv_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] quo_i,
   input  logic [WIDTH-1:0] dvsr_i,
   output logic [WIDTH-1:0] rem_o,
   output logic [WIDTH-1:0] quo_o
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;

   always_comb begin
      // {rem, quo} << 1 : the next dividend bit moves from quo's MSB into rem.
      shifted = {rem_i, quo_i[WIDTH-1]};
      trial   = shifted - {1'b0, dvsr_i};
      if (!trial[WIDTH]) begin
         rem_o = trial[WIDTH-1:0];
         quo_o = {quo_i[WIDTH-2:0], 1'b1};
      end else begin
         rem_o = shifted[WIDTH-1:0];
         quo_o = {quo_i[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle signed divider: latches operand magnitudes on start, runs one
// restoring step per clock for WIDTH clocks, then applies sign correction and
// pulses ready_o with quotient/remainder and a divide-by-zero flag.
// Ports:
//   clk_i        : clock, rising edge
//   clr_n_i      : synchronous active-low reset
//   start_i      : one-cycle request, sampled only in IDLE
//   dividend_i   : two's-complement dividend
//   divisor_i    : two's-complement divisor
//   busy_o       : high while a non-zero-divisor division is in flight
//   ready_o      : one-cycle completion pulse
//   quotient_o   : signed quotient, truncated toward zero
//   remainder_o  : signed remainder, sign follows dividend
//   exception_o  : divide-by-zero flag
module div_seq
   import multdiv_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH
) (
   input  logic             clk_i,
   input  logic             clr_n_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic             busy_o,
   output logic             ready_o,
   output logic [WIDTH-1:0] quotient_o,
   output logic [WIDTH-1:0] remainder_o,
   output logic             exception_o
);

   localparam int unsigned     CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

   div_state_e state_q, state_d;

   logic [CW-1:0]    cnt_q,  cnt_d;
   logic [WIDTH-1:0] rem_q,  rem_d;
   logic [WIDTH-1:0] quo_q,  quo_d;
   logic [WIDTH-1:0] dvsr_q, dvsr_d;
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;
   logic             zero_q, zero_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] remd_q, remd_d;
   logic             exc_q,  exc_d;
   logic             rdy_q,  rdy_d;

   logic [WIDTH-1:0] step_rem;
   logic [WIDTH-1:0] step_quo;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_i  (rem_q),
      .quo_i  (quo_q),
      .dvsr_i (dvsr_q),
      .rem_o  (step_rem),
      .quo_o  (step_quo)
   );

   // State register
   always_ff @(posedge clk_i) begin
      if (!clr_n_i) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start_i) state_d = (divisor_i == '0) ? FIX : RUN;
         RUN:     if (cnt_q == LAST) state_d = FIX;
         FIX:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs: a divide-by-zero passes through FIX without ever being busy.
   always_comb begin
      busy_o = (state_q == RUN) || ((state_q == FIX) && !zero_q);
   end

   // Datapath next-state
   always_comb begin
      cnt_d  = cnt_q;
      rem_d  = rem_q;
      quo_d  = quo_q;
      dvsr_d = dvsr_q;
      qneg_d = qneg_q;
      rneg_d = rneg_q;
      zero_d = zero_q;
      quot_d = quot_q;
      remd_d = remd_q;
      exc_d  = exc_q;
      rdy_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               zero_d = (divisor_i == '0);
               if (divisor_i != '0) begin
                  // Negating -2^(WIDTH-1) yields itself, which is the correct unsigned magnitude.
                  quo_d  = dividend_i[WIDTH-1] ? -dividend_i : dividend_i;
                  dvsr_d = divisor_i[WIDTH-1]  ? -divisor_i  : divisor_i;
                  qneg_d = dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1];
                  rneg_d = dividend_i[WIDTH-1];
                  rem_d  = '0;
                  cnt_d  = '0;
               end
            end
         end
         RUN: begin
            rem_d = step_rem;
            quo_d = step_quo;
            cnt_d = cnt_q + CW'(1);
         end
         FIX: begin
            if (zero_q) begin
               quot_d = '0;
               remd_d = '0;
            end else begin
               quot_d = qneg_q ? -quo_q : quo_q;
               remd_d = rneg_q ? -rem_q : rem_q;
            end
            exc_d = zero_q;
            rdy_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!clr_n_i) begin
         cnt_q  <= '0;
         rem_q  <= '0;
         quo_q  <= '0;
         dvsr_q <= '0;
         qneg_q <= 1'b0;
         rneg_q <= 1'b0;
         zero_q <= 1'b0;
         quot_q <= '0;
         remd_q <= '0;
         exc_q  <= 1'b0;
         rdy_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         dvsr_q <= dvsr_d;
         qneg_q <= qneg_d;
         rneg_q <= rneg_d;
         zero_q <= zero_d;
         quot_q <= quot_d;
         remd_q <= remd_d;
         exc_q  <= exc_d;
         rdy_q  <= rdy_d;
      end
   end

   assign ready_o     = rdy_q;
   assign quotient_o  = quot_q;
   assign remainder_o = remd_q;
   assign exception_o = exc_q;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed corner cases plus randomized
// operands checked against an arithmetic reference model.
module tb_div_seq;

   localparam int unsigned W = 32;

   logic         clk = 1'b0;
   logic         clr_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         busy, ready, exception;
   logic [W-1:0] quotient, remainder;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   div_seq #(.WIDTH(W)) dut (
      .clk_i       (clk),
      .clr_n_i     (clr_n),
      .start_i     (start),
      .dividend_i  (dividend),
      .divisor_i   (divisor),
      .busy_o      (busy),
      .ready_o     (ready),
      .quotient_o  (quotient),
      .remainder_o (remainder),
      .exception_o (exception)
   );

   // Directed cases with hand-derived results.
   logic [W-1:0] d_a [4] = '{32'd100, 32'hFFFF_FF9C, 32'd100, 32'h8000_0000};
   logic [W-1:0] d_b [4] = '{32'd7,   32'd7,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
   logic [W-1:0] d_q [4] = '{32'd14,  32'hFFFF_FFF2, 32'hFFFF_FFF2, 32'h8000_0000};
   logic [W-1:0] d_r [4] = '{32'd2,   32'hFFFF_FFFE, 32'd2,         32'd0};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: signed division truncating toward zero, computed wide so the
   // most-negative / -1 case wraps back to itself when narrowed.
   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] q, output logic [W-1:0] r,
                                 output logic e);
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (b == '0) begin
         q = '0; r = '0; e = 1'b1;
      end else begin
         q = W'(sa / sb); r = W'(sa % sb); e = 1'b0;
      end
   endfunction

   // Issues one start and waits (bounded) for ready; lat = edges after E0.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic e, output int lat,
                         output logic busy_seen, output logic busy_at_ready);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      lat       = 0;
      busy_seen = busy;
      while (!ready && lat < 100) begin
         tick();
         lat++;
         if (busy && !ready) busy_seen = 1'b1;
      end
      q = quotient;
      r = remainder;
      e = exception;
      busy_at_ready = busy;
   endtask

   task automatic test_reset();
      clr_n = 1'b0;
      dividend = 32'd100;
      divisor  = 32'd7;
      start    = 1'b1;
      tick();
      tick();
      start = 1'b0;
      checks++;
      if ({busy, ready, exception} !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags: got busy=%b ready=%b exc=%b, want 0 0 0", busy, ready, exception);
      end
      checks++;
      if (quotient !== '0) begin
         errors++;
         $display("FAIL reset_quotient: got %h, want 0", quotient);
      end
      checks++;
      if (remainder !== '0) begin
         errors++;
         $display("FAIL reset_remainder: got %h, want 0", remainder);
      end
      clr_n = 1'b1;
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle_busy: got %b, want 0", busy);
      end
   endtask

   task automatic test_directed();
      logic [W-1:0] q, r;
      logic e, bs, br;
      int lat;
      for (int i = 0; i < 4; i++) begin
         run_op(d_a[i], d_b[i], q, r, e, lat, bs, br);
         checks++;
         if ({q, r, e} !== {d_q[i], d_r[i], 1'b0}) begin
            errors++;
            $display("FAIL directed_%0d_result: got q=%h r=%h e=%b, want q=%h r=%h e=0",
                     i, q, r, e, d_q[i], d_r[i]);
         end
         checks++;
         if (lat !== 33) begin
            errors++;
            $display("FAIL directed_%0d_latency: got %0d edges, want 33", i, lat);
         end
         checks++;
         if ({bs, br} !== 2'b10) begin
            errors++;
            $display("FAIL directed_%0d_busy: got seen=%b at_ready=%b, want 1 0", i, bs, br);
         end
         tick();
         checks++;
         if ({ready, quotient} !== {1'b0, d_q[i]}) begin
            errors++;
            $display("FAIL directed_%0d_pulse_hold: got ready=%b q=%h, want ready=0 q=%h",
                     i, ready, quotient, d_q[i]);
         end
      end
   endtask

   task automatic test_div_zero();
      logic [W-1:0] q, r;
      logic e, bs, br;
      int lat;
      run_op(32'd7, 32'd0, q, r, e, lat, bs, br);
      checks++;
      if ({q, r, e} !== {32'd0, 32'd0, 1'b1}) begin
         errors++;
         $display("FAIL div0_result: got q=%h r=%h e=%b, want q=0 r=0 e=1", q, r, e);
      end
      checks++;
      if (lat !== 1) begin
         errors++;
         $display("FAIL div0_latency: got %0d edges, want 1", lat);
      end
      checks++;
      if ({bs, br} !== 2'b00) begin
         errors++;
         $display("FAIL div0_busy: got seen=%b at_ready=%b, want 0 0", bs, br);
      end
      tick();
      checks++;
      if ({ready, exception} !== 2'b01) begin
         errors++;
         $display("FAIL div0_hold: got ready=%b exc=%b, want 0 1", ready, exception);
      end
      run_op(32'd9, 32'd3, q, r, e, lat, bs, br);
      checks++;
      if ({q, r, e, lat} !== {32'd3, 32'd0, 1'b0, 33}) begin
         errors++;
         $display("FAIL after_div0: got q=%h r=%h e=%b lat=%0d, want q=3 r=0 e=0 lat=33",
                  q, r, e, lat);
      end
      tick();
   endtask

   task automatic test_ignore_start();
      int n;
      dividend = 32'd50;
      divisor  = 32'd5;
      start    = 1'b1;
      tick();
      start = 1'b0;
      repeat (9) tick();
      dividend = 32'd9;
      divisor  = 32'd3;
      start    = 1'b1;
      tick();
      start = 1'b0;
      n = 10;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL ignore_busy: got %b, want 1", busy);
      end
      while (!ready && n < 100) begin
         tick();
         n++;
      end
      checks++;
      if ({n, quotient, remainder} !== {33, 32'd10, 32'd0}) begin
         errors++;
         $display("FAIL ignore_result: got lat=%0d q=%h r=%h, want lat=33 q=a r=0",
                  n, quotient, remainder);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] q, r, mq, mr;
      logic e, me, bs, br;
      int lat;
      // Entered with ready high from the previous task: this start lands in the ready cycle.
      run_op(32'd1000, 32'hFFFF_FFF7, q, r, e, lat, bs, br);
      model(32'd1000, 32'hFFFF_FFF7, mq, mr, me);
      checks++;
      if ({q, r, e, lat} !== {mq, mr, me, 33}) begin
         errors++;
         $display("FAIL b2b_first: got q=%h r=%h e=%b lat=%0d, want q=%h r=%h e=%b lat=33",
                  q, r, e, lat, mq, mr, me);
      end
      run_op(32'hFFFF_FFB3, 32'd5, q, r, e, lat, bs, br);
      model(32'hFFFF_FFB3, 32'd5, mq, mr, me);
      checks++;
      if ({q, r, e, lat} !== {mq, mr, me, 33}) begin
         errors++;
         $display("FAIL b2b_second: got q=%h r=%h e=%b lat=%0d, want q=%h r=%h e=%b lat=33",
                  q, r, e, lat, mq, mr, me);
      end
      tick();
   endtask

   task automatic test_abort();
      logic [W-1:0] q, r;
      logic e, bs, br, seen;
      int lat;
      dividend = 32'd1000;
      divisor  = 32'd3;
      start    = 1'b1;
      tick();
      start = 1'b0;
      repeat (11) tick();
      clr_n = 1'b0;
      tick();
      checks++;
      if ({busy, ready, exception, quotient, remainder} !== '0) begin
         errors++;
         $display("FAIL abort_clear: got busy=%b ready=%b exc=%b q=%h r=%h, want all 0",
                  busy, ready, exception, quotient, remainder);
      end
      clr_n = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         tick();
         if (ready || busy) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL abort_no_ready: got activity=%b, want 0", seen);
      end
      run_op(32'd45, 32'd9, q, r, e, lat, bs, br);
      checks++;
      if ({q, r, e, lat} !== {32'd5, 32'd0, 1'b0, 33}) begin
         errors++;
         $display("FAIL abort_fresh: got q=%h r=%h e=%b lat=%0d, want q=5 r=0 e=0 lat=33",
                  q, r, e, lat);
      end
      tick();
   endtask

   function automatic logic [W-1:0] pick(input int unsigned kind);
      case (kind)
         0:       return 32'h8000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'd1;
         3:       return 32'd0;
         4, 5:    return W'(32'($urandom_range(0, 40)) - 32'd20);
         default: return W'($urandom);
      endcase
   endfunction

   task automatic test_random();
      logic [W-1:0] a, b, q, r, mq, mr;
      logic e, me, bs, br;
      int lat, want_lat;
      for (int i = 0; i < 40; i++) begin
         a = pick($urandom_range(0, 9));
         b = pick($urandom_range(0, 12));
         model(a, b, mq, mr, me);
         want_lat = (b == '0) ? 1 : 33;
         run_op(a, b, q, r, e, lat, bs, br);
         checks++;
         if ({q, r, e} !== {mq, mr, me}) begin
            errors++;
            $display("FAIL random_%0d_result %h/%h: got q=%h r=%h e=%b, want q=%h r=%h e=%b",
                     i, a, b, q, r, e, mq, mr, me);
         end
         checks++;
         if ({lat, bs, br} !== {want_lat, (b != '0), 1'b0}) begin
            errors++;
            $display("FAIL random_%0d_timing: got lat=%0d busy_seen=%b busy_at_ready=%b, want lat=%0d busy_seen=%b busy_at_ready=0",
                     i, lat, bs, br, want_lat, (b != '0));
         end
         repeat ($urandom_range(0, 2)) tick();
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_div_zero();
      test_ignore_start();
      test_back_to_back();
      test_abort();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/div_seq.md
# div_seq

Multi-cycle signed integer divider for the processor's multdiv unit. It latches two operands on a `start` pulse and runs one restoring-division step per clock, using an internal iteration counter. It then applies sign correction and pulses `ready` with quotient, remainder and exception flag. It sits between the execute-stage operand latches and the writeback mux, and stalls the pipeline while `busy` is high.

## Interface
- `WIDTH`, 32: operand and result width in bits; must be ≥ 2.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `clr_n`  in  1: synchronous, active-low reset.
- `start`  in  1: sampled only in IDLE; one-cycle request to begin a division.
- `dividend`  in  WIDTH: two's-complement dividend, sampled with `start`.
- `divisor`  in  WIDTH: two's-complement divisor, sampled with `start`.
- `busy`  out  1: high from the edge after `start` is accepted until the edge that raises `ready`.
- `ready`  out  1: one-cycle completion pulse.
- `quotient`  out  WIDTH: signed quotient, truncated toward zero.
- `remainder`  out  WIDTH: signed remainder; its sign follows the dividend.
- `exception`  out  1: divide-by-zero flag, valid while `ready` is high.

## Operation
- States: IDLE, RUN, FIX.
- IDLE, `start`=1, divisor≠0:
  - latch |dividend| and |divisor| as unsigned magnitudes; -2^(WIDTH-1) is kept as an unsigned magnitude.
  - record the quotient sign (dividend sign XOR divisor sign) and the remainder sign (dividend sign).
  - clear the partial remainder and the counter; go to RUN.
- IDLE, `start`=1, divisor=0: go straight to FIX with the zero flag set.
- RUN, each edge, one restoring step:
  - shift {partial remainder, quotient register} left by 1.
  - trial = partial remainder − divisor magnitude, computed WIDTH+1 bits wide.
  - if trial ≥ 0: keep the trial and set quotient bit 0 to 1; otherwise keep the old value and set it to 0.
  - counter += 1; after the WIDTH-th step, go to FIX.
- FIX, one edge:
  - negate the quotient and/or remainder per the recorded signs and register them onto the outputs.
  - drive `exception` from the zero flag; pulse `ready`; return to IDLE.
  - divide-by-zero outputs: quotient=0, remainder=0, exception=1.
- Outputs hold their values until the next FIX edge or reset. `exception` clears at the next FIX edge.
- `start` while RUN or FIX is ignored, with no queuing.
- -2^(WIDTH-1) / -1 gives quotient 0x80000000 (wraps), remainder 0, exception=0.
- All arithmetic is modulo 2^WIDTH except the WIDTH+1-bit trial subtract.

## Timing
- Reset (clr_n=0 at an edge) sets: state=IDLE, counter=0, busy=0, ready=0, exception=0, quotient=0, remainder=0.
- Reset mid-operation aborts the division; no `ready` pulse follows.
- Let E0 be the edge that samples `start`. Normal case:
  - `busy` rises at E0 and falls at E0+WIDTH+1.
  - `ready`=1 from E0+WIDTH+1 to E0+WIDTH+2; 33 edges for WIDTH=32.
- Divide by zero: `ready` and `exception` rise at E0+1; `busy` stays low.
- Back-to-back: `start` in the cycle where `ready`=1 is accepted, because the state is IDLE again. Minimum spacing between accepted starts is WIDTH+2 edges.

## Structure
- Shared package `multdiv_pkg`: state enum (IDLE, RUN, FIX), `DIV_WIDTH`=32, counter width = $clog2(WIDTH)+1.
- One sub-module, `div_step`: combinational shift/trial-subtract/select for a single restoring iteration, instantiated once inside RUN.
- FSM, counter and sign handling stay in `div_seq`.

## Test plan
- 100 / 7 → quotient=14, remainder=2, exception=0; `ready` exactly at E0+33 and exactly one cycle long.
- −100 / 7 → quotient=0xFFFFFFF2, remainder=0xFFFFFFFE. 100 / −7 → quotient=0xFFFFFFF2, remainder=2.
- 7 / 0 → `ready` and `exception` at E0+1, quotient=0, remainder=0, `busy` never high. The next 9 / 3 → quotient=3, exception=0.
- 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0, exception=0.
- Start 50/5, then pulse `start` with 9/3 at E0+10 → that pulse is ignored; result is quotient=10 at E0+33. A `start` in the `ready` cycle is accepted.
- clr_n=0 at E0+12 mid-division → all outputs are 0 on the next edge and no `ready` follows. A fresh 45 / 9 then yields quotient=5.
